xor_update_issuer: RTL and testbench

Read-modify-write front end for the per-lane XOR hash table. It accepts update requests, reads the current entry, XORs each enabled lane with its key, and drives the write interface of the table (`write_reg_0_index`/`write_reg_0_valid`, then `arbiter_result`/`write_reg_11_xor` two cycles later). The table has no forwarding path, so this block stalls any request whose index is still in flight.

---
 rtl/xor_update_issuer.sv | 149 ++++++++++++++
 tb/tb_xor_update_issuer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_update_issuer.sv
// Read-modify-write issuer for the per-lane XOR hash table, with a hazard scoreboard
// that stalls requests whose index is still in flight. Optional counters: XOR_ISSUER_STATS_EN.
module xor_update_issuer #(
    parameter int unsigned NUM_MUL     = 4,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INDEX_WIDTH-1:0]        in_index,
    input  logic [NUM_MUL-1:0]            in_mask,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] in_key,
    output logic [INDEX_WIDTH-1:0]        rd_index,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] rd_data,
    output logic                          wr_valid,
    output logic [INDEX_WIDTH-1:0]        wr_index,
    output logic [NUM_MUL-1:0]            wr_mask,
    output logic [NUM_MUL*DATA_WIDTH-1:0] wr_xor,
    output logic [31:0]                   stat_accepted,
    output logic [31:0]                   stat_stall
);

    localparam int unsigned KW      = NUM_MUL * DATA_WIDTH;
    localparam int unsigned NST     = RD_LAT + 1;
    localparam int unsigned HAZ_WIN = RD_LAT + 7;

    logic                   st_vld_q  [1:NST];
    logic                   st_vld_d  [1:NST];
    logic [NUM_MUL-1:0]     st_mask_q [1:NST];
    logic [NUM_MUL-1:0]     st_mask_d [1:NST];
    logic [KW-1:0]          st_key_q  [1:NST];
    logic [KW-1:0]          st_key_d  [1:NST];
    logic [INDEX_WIDTH-1:0] st_idx_q  [1:RD_LAT];
    logic [INDEX_WIDTH-1:0] st_idx_d  [1:RD_LAT];

    // Slot 0 of the hazard window is the request being accepted this cycle;
    // the registered slots below hold the remaining HAZ_WIN-1 ages.
    logic                   haz_vld_q [1:HAZ_WIN-1];
    logic                   haz_vld_d [1:HAZ_WIN-1];
    logic [INDEX_WIDTH-1:0] haz_idx_q [1:HAZ_WIN-1];
    logic [INDEX_WIDTH-1:0] haz_idx_d [1:HAZ_WIN-1];

    logic [NUM_MUL-1:0]     wr_mask_q, wr_mask_d;
    logic [KW-1:0]          wr_xor_q, wr_xor_d;

    logic hit;
    logic accept;

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 1; i < HAZ_WIN; i++) begin
            if (haz_vld_q[i] && haz_idx_q[i] == in_index) hit = 1'b1;
        end
    end

    assign in_ready = !reset && !(in_valid && hit);
    assign accept   = in_valid && in_ready;

    always_comb begin
        st_vld_d  = st_vld_q;
        st_mask_d = st_mask_q;
        st_key_d  = st_key_q;
        st_idx_d  = st_idx_q;
        haz_vld_d = haz_vld_q;
        haz_idx_d = haz_idx_q;

        st_vld_d[1]  = accept;
        st_mask_d[1] = accept ? in_mask  : st_mask_q[1];
        st_key_d[1]  = accept ? in_key   : st_key_q[1];
        st_idx_d[1]  = accept ? in_index : st_idx_q[1];
        for (int unsigned i = 2; i <= NST; i++) begin
            st_vld_d[i]  = st_vld_q[i-1];
            st_mask_d[i] = st_mask_q[i-1];
            st_key_d[i]  = st_key_q[i-1];
        end
        for (int unsigned i = 2; i <= RD_LAT; i++) begin
            st_idx_d[i] = st_idx_q[i-1];
        end

        haz_vld_d[1] = accept;
        haz_idx_d[1] = in_index;
        for (int unsigned i = 2; i < HAZ_WIN; i++) begin
            haz_vld_d[i] = haz_vld_q[i-1];
            haz_idx_d[i] = haz_idx_q[i-1];
        end

        // rd_data for stage NST arrives in the same cycle; XOR is registered here
        wr_mask_d = st_vld_q[NST] ? st_mask_q[NST] : '0;
        wr_xor_d  = st_vld_q[NST] ? (rd_data ^ st_key_q[NST]) : wr_xor_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_vld_q  <= '{default: '0};
            st_mask_q <= '{default: '0};
            st_key_q  <= '{default: '0};
            st_idx_q  <= '{default: '0};
            haz_vld_q <= '{default: '0};
            haz_idx_q <= '{default: '0};
            wr_mask_q <= '0;
            wr_xor_q  <= '0;
        end else begin
            st_vld_q  <= st_vld_d;
            st_mask_q <= st_mask_d;
            st_key_q  <= st_key_d;
            st_idx_q  <= st_idx_d;
            haz_vld_q <= haz_vld_d;
            haz_idx_q <= haz_idx_d;
            wr_mask_q <= wr_mask_d;
            wr_xor_q  <= wr_xor_d;
        end
    end

    assign rd_index = st_idx_q[1];
    assign wr_valid = st_vld_q[RD_LAT];
    assign wr_index = st_idx_q[RD_LAT];
    assign wr_mask  = wr_mask_q;
    assign wr_xor   = wr_xor_q;

`ifdef XOR_ISSUER_STATS_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        acc_d   = accept ? acc_q + 32'd1 : acc_q;
        stall_d = (in_valid && !in_ready && !reset) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            acc_q   <= acc_d;
            stall_q <= stall_d;
        end
    end

    assign stat_accepted = acc_q;
    assign stat_stall    = stall_q;
`else
    assign stat_accepted = '0;
    assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_xor_update_issuer.sv
// Directed bench for xor_update_issuer with a behavioural table model (RD_LAT=2 read,
// commit at accept+8). Stat checks follow XOR_ISSUER_STATS_EN.
module tb_xor_update_issuer;

    localparam int unsigned KW = 256;
    localparam logic [KW-1:0] INIT_ENTRY = {4{64'hF0}};

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [11:0]     in_index;
    logic [3:0]      in_mask;
    logic [KW-1:0]   in_key;
    logic [11:0]     rd_index;
    logic [KW-1:0]   rd_data;
    logic            wr_valid;
    logic [11:0]     wr_index;
    logic [3:0]      wr_mask;
    logic [KW-1:0]   wr_xor;
    logic [31:0]     stat_accepted;
    logic [31:0]     stat_stall;

    int n_total = 0;
    int n_bad   = 0;

    xor_update_issuer #(
        .NUM_MUL     (4),
        .INDEX_WIDTH (12),
        .DATA_WIDTH  (64),
        .RD_LAT      (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_index      (in_index),
        .in_mask       (in_mask),
        .in_key        (in_key),
        .rd_index      (rd_index),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_index      (wr_index),
        .wr_mask       (wr_mask),
        .wr_xor        (wr_xor),
        .stat_accepted (stat_accepted),
        .stat_stall    (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model: two-cycle read, write halves paired and committed four cycles after wr_mask
    logic [KW-1:0] mem [0:4095] = '{default: INIT_ENTRY};
    logic [KW-1:0] rd_p1 = '0;
    logic          wv1 = 1'b0, wv2 = 1'b0;
    logic [11:0]   wi1 = '0, wi2 = '0;
    logic          cm_v [0:3] = '{default: 1'b0};
    logic [11:0]   cm_i [0:3] = '{default: '0};
    logic [3:0]    cm_m [0:3] = '{default: '0};
    logic [KW-1:0] cm_x [0:3] = '{default: '0};

    function automatic logic [KW-1:0] merge(input logic [KW-1:0] old, input logic [3:0] m,
                                            input logic [KW-1:0] x);
        logic [KW-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*64 +: 64] = x[i*64 +: 64];
        return r;
    endfunction

    initial rd_data = '0;

    always @(posedge clk) begin
        rd_p1   <= mem[rd_index];
        rd_data <= rd_p1;
        wv1 <= wr_valid;
        wi1 <= wr_index;
        wv2 <= wv1;
        wi2 <= wi1;
        cm_v[0] <= wv2;
        cm_i[0] <= wi2;
        cm_m[0] <= wr_mask;
        cm_x[0] <= wr_xor;
        for (int i = 1; i < 4; i++) begin
            cm_v[i] <= cm_v[i-1];
            cm_i[i] <= cm_i[i-1];
            cm_m[i] <= cm_m[i-1];
            cm_x[i] <= cm_x[i-1];
        end
        if (cm_v[3]) mem[cm_i[3]] <= merge(mem[cm_i[3]], cm_m[3], cm_x[3]);
    end

    task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] idx, input logic [3:0] m,
                         input logic [KW-1:0] k);
        in_valid = v;
        in_index = idx;
        in_mask  = m;
        in_key   = k;
    endtask

    logic [31:0] acc0, stall0;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0);
        repeat (3) tick();

        // Reset state, with a request offered
        drive(1'b1, 12'h005, 4'hF, '0);
        #1;
        chk("rst_ready",  in_ready, 0);
        chk("rst_wvalid", wr_valid, 0);
        chk("rst_wmask",  wr_mask, 0);
        chk("rst_widx",   wr_index, 0);
        chk("rst_wxor",   wr_xor, 0);
        chk("rst_rdidx",  rd_index, 0);
        chk("rst_acc",    stat_accepted, 0);
        chk("rst_stall",  stat_stall, 0);
        drive(1'b0, '0, '0, '0);
        reset = 1'b0;
        tick();

        // Single update
        drive(1'b1, 12'h005, 4'b0101, {64'h4, 64'h3, 64'h2, 64'h1});
        #1 chk("s_ready", in_ready, 1);
        tick();
        drive(1'b0, '0, '0, '0);
        #1 chk("s_rdidx", rd_index, 12'h005);
        tick();
        #1 chk("s_wvalid", wr_valid, 1);
        chk("s_widx", wr_index, 12'h005);
        tick();
        #1 chk("s_wvalid_off", wr_valid, 0);
        tick();
        #1 chk("s_wmask", wr_mask, 4'b0101);
        chk("s_wxor", wr_xor, {64'hF4, 64'hF3, 64'hF2, 64'hF1});
        tick();
        #1 chk("s_wmask_off", wr_mask, 0);
        repeat (10) tick();

        // Back-to-back distinct indices
        for (int j = 0; j < 8; j++) begin
            if (j < 4) drive(1'b1, 12'(j + 1), 4'hF, '0);
            else       drive(1'b0, '0, '0, '0);
            #1;
            if (j < 4) chk("b2b_ready", in_ready, 1);
            chk("b2b_wvalid", wr_valid, (j >= 2 && j <= 5));
            if (j >= 2 && j <= 5) chk("b2b_widx", wr_index, 12'(j - 1));
            tick();
        end
        repeat (10) tick();

        // Same-index hazard on index 7
        acc0   = stat_accepted;
        stall0 = stat_stall;
        drive(1'b1, 12'h007, 4'b0011, {64'h44, 64'h33, 64'h22, 64'h11});
        #1 chk("h_ready0", in_ready, 1);
        tick();
        drive(1'b1, 12'h007, 4'hF, {64'h4, 64'h3, 64'h2, 64'h1});
        for (int k = 1; k <= 9; k++) begin
            #1 chk("h_ready", in_ready, (k == 9));
            if (k == 4) chk("h_wmask1", wr_mask, 4'b0011);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        #1;
`ifdef XOR_ISSUER_STATS_EN
        chk("h_stall_cnt", stat_stall - stall0, 8);
        chk("h_acc_cnt", stat_accepted - acc0, 2);
`else
        chk("h_stall_off", stat_stall, 0);
        chk("h_acc_off", stat_accepted, 0);
`endif
        repeat (3) tick();
        #1 chk("h_wmask2", wr_mask, 4'hF);
        chk("h_wxor2", wr_xor, {64'hF4, 64'hF3, 64'hD0, 64'hE0});
        repeat (12) tick();

        // Zero mask on index 0x0A
        stall0 = stat_stall;
        drive(1'b1, 12'h00A, 4'h0, {4{64'h55}});
        #1 chk("z_ready0", in_ready, 1);
        tick();
        for (int k = 1; k <= 9; k++) begin
            #1 chk("z_ready", in_ready, (k == 9));
            if (k == 2) begin
                chk("z_wvalid", wr_valid, 1);
                chk("z_widx", wr_index, 12'h00A);
            end
            if (k == 3) chk("z_wvalid_off", wr_valid, 0);
            if (k == 4) chk("z_wmask", wr_mask, 0);
            tick();
        end
        drive(1'b0, '0, '0, '0);
`ifdef XOR_ISSUER_STATS_EN
        #1 chk("z_stall_cnt", stat_stall - stall0, 8);
`endif
        tick();
        #1 chk("z_wvalid2", wr_valid, 1);
        repeat (12) tick();

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'(32 + i), 4'hF, {4{64'h0F}});
            #1 chk("r_ready", in_ready, 1);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        reset = 1'b1;
        #1 chk("r_ready_rst", in_ready, 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 3) drive(1'b1, 12'(32 + k), 4'hF, {4{64'h0F}});
            else       drive(1'b0, '0, '0, '0);
            #1;
            if (k < 3) chk("r_reready", in_ready, 1);
            chk("r_wvalid", wr_valid, (k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) chk("r_widx", wr_index, 12'(32 + k - 2));
            chk("r_wmask", wr_mask, (k >= 4 && k <= 6) ? 4'hF : 4'h0);
            if (k == 0) begin
                chk("r_rdidx_clr", rd_index, 0);
                chk("r_widx_clr", wr_index, 0);
                chk("r_acc_clr", stat_accepted, 0);
            end
            tick();
        end
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
